// File: rtl/mem_pkg.sv
// Shared types for the memory responder slice.
// Op decode helper used when a request is latched.
package mem_pkg;

  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } mem_op_t;

  function automatic mem_op_t decode_op(
    input logic rd,
    input logic wr
  );
    mem_op_t op;
    op = OP_RD;
    if (rd && wr) op = OP_BAD;
    else if (wr) op = OP_WR;
    return op;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable wait states
// and a one-cycle ready strobe.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_t        state;
  mem_state_t        state_nxt;
  mem_op_t           op_q;
  mem_op_t           op_cur;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_cur;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_cur;
  logic [DATA_W-1:0] arr_rd;
  logic [3:0]        cnt;
  logic              req;
  logic              in_idle;
  logic              in_range;
  logic              enter_resp;
  logic              we;

  assign req     = mem_read | mem_write;
  assign in_idle = (state == IDLE);

  // With zero wait states RESP is entered straight from IDLE,
  // so the live request is used instead of the latched copy.
  assign op_cur    = in_idle ? decode_op(mem_read, mem_write) : op_q;
  assign addr_cur  = in_idle ? addr  : addr_q;
  assign wdata_cur = in_idle ? wdata : wdata_q;

  assign in_range   = 32'(addr_cur) < 32'(DEPTH);
  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  assign we         = enter_resp && (op_cur == OP_WR) && in_range;

  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(addr_cur[AW-1:0]),
    .wdata(wdata_cur),
    .raddr(addr_cur[AW-1:0]),
    .rdata(arr_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req)
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      if (in_idle && req) begin
        op_q    <= op_cur;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        if (op_cur == OP_BAD || !in_range) begin
          rdata <= '0;
          err   <= 1'b1;
        end else if (op_cur == OP_RD) begin
          rdata <= arr_rd;
          err   <= 1'b0;
        end else begin
          err   <= 1'b0;
        end
      end else if (state == RESP) begin
        err <= 1'b0;
      end
    end
  end

endmodule
